// File: rtl/output_mem_ctrl_pkg.sv
// Shared constants, rotation and state encodings for the output memory controller.
package output_mem_ctrl_pkg;

    localparam int          NPIX          = 64;
    localparam int          NWORDS        = 48;
    localparam int          BYTES_PER_PIX = 3;
    localparam logic [7:0]  PARK_ADDR     = 8'hFF;

    localparam logic [1:0]  ROT_0   = 2'd0;
    localparam logic [1:0]  ROT_90  = 2'd1;
    localparam logic [1:0]  ROT_180 = 2'd2;
    localparam logic [1:0]  ROT_270 = 2'd3;

    localparam logic [2:0]  ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0]  ST_FILL_ENC    = 3'd1;
    localparam logic [2:0]  ST_FLUSH_ENC   = 3'd2;
    localparam logic [2:0]  ST_WAIT_A_ENC  = 3'd3;
    localparam logic [2:0]  ST_WAIT_B_ENC  = 3'd4;
    localparam logic [2:0]  ST_PRESENT_ENC = 3'd5;
    localparam logic [2:0]  ST_FIN_ENC     = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_FILL    = ST_FILL_ENC,
        ST_FLUSH   = ST_FLUSH_ENC,
        ST_WAIT_A  = ST_WAIT_A_ENC,
        ST_WAIT_B  = ST_WAIT_B_ENC,
        ST_PRESENT = ST_PRESENT_ENC,
        ST_FIN     = ST_FIN_ENC
    } state_e;

    // Byte address k of packed word w: 4*w+k is just the concatenation.
    function automatic logic [7:0] word_byte_addr(input logic [5:0] w, input logic [1:0] k);
        return {w, k};
    endfunction

endpackage

// File: rtl/output_mem_ctrl_rot_addr.sv
// Rotated destination base byte address (3*d) for raster pixel index n.
module omctl_rot_addr
    import output_mem_ctrl_pkg::*;
(
    input  logic [5:0] n_i,
    input  logic [1:0] rot_i,
    output logic [7:0] base_o
);
    logic [2:0] r, c, rr, cc;
    logic [5:0] d;

    assign r = n_i[5:3];
    assign c = n_i[2:0];

    // Map source (row, col) to its rotated position; 7-x is ~x on 3 bits.
    always_comb begin
        rr = r;
        cc = c;
        case (rot_i)
            ROT_90:  begin rr = c;  cc = ~r; end
            ROT_180: begin rr = ~r; cc = ~c; end
            ROT_270: begin rr = ~c; cc = r;  end
            default: begin rr = r;  cc = c;  end
        endcase
    end

    assign d      = {rr, cc};
    assign base_o = {1'b0, d, 1'b0} + {2'b00, d};

endmodule

// File: rtl/output_mem_ctrl.sv
// Fill/drain sequencer for the 192-byte output pixel memory (one 8x8 RGB tile).
module output_mem_ctrl
    import output_mem_ctrl_pkg::*;
(
    input  logic       I_OMCTL_HCLK,
    input  logic       I_OMCTL_HRESET_N,
    input  logic       I_OMCTL_START,
    input  logic [1:0] I_OMCTL_ROT,
    input  logic       I_OMCTL_PIX_VALID,
    output logic       O_OMCTL_PIX_READY,
    input  logic [7:0] I_OMCTL_PIX_B,
    input  logic [7:0] I_OMCTL_PIX_G,
    input  logic [7:0] I_OMCTL_PIX_R,
    output logic [7:0] O_OMCTL_PIXEL_B,
    output logic [7:0] O_OMCTL_PIXEL_G,
    output logic [7:0] O_OMCTL_PIXEL_R,
    output logic [7:0] O_OMCTL_IN_ADDRB,
    output logic [7:0] O_OMCTL_IN_ADDRG,
    output logic [7:0] O_OMCTL_IN_ADDRR,
    output logic [7:0] O_OMCTL_OUT_ADDR0,
    output logic [7:0] O_OMCTL_OUT_ADDR1,
    output logic [7:0] O_OMCTL_OUT_ADDR2,
    output logic [7:0] O_OMCTL_OUT_ADDR3,
    output logic       O_OMCTL_WVALID,
    input  logic       I_OMCTL_WREADY,
    output logic [5:0] O_OMCTL_WORD_IDX,
    output logic       O_OMCTL_BUSY,
    output logic       O_OMCTL_DONE
);
    state_e           state_q, state_d;
    logic [5:0]       n_q, n_d;
    logic [5:0]       w_q, w_d;
    logic [1:0]       rot_q, rot_d;
    logic [2:0][7:0]  in_addr_q, in_addr_d;   // [0]=B [1]=G [2]=R
    logic [2:0][7:0]  pix_q, pix_d;
    logic [3:0][7:0]  out_addr_q, out_addr_d;
    logic [7:0]       base;
    logic             pix_hs;

    omctl_rot_addr u_rot_addr (
        .n_i    (n_q),
        .rot_i  (rot_q),
        .base_o (base)
    );

    assign pix_hs = (state_q == ST_FILL) && I_OMCTL_PIX_VALID;

    // Next-state logic; write addresses park unless a pixel is accepted this cycle.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        w_d        = w_q;
        rot_d      = rot_q;
        in_addr_d  = {PARK_ADDR, PARK_ADDR, PARK_ADDR};
        pix_d      = pix_q;
        out_addr_d = out_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (I_OMCTL_START) begin
                    rot_d   = I_OMCTL_ROT;
                    n_d     = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (pix_hs) begin
                    in_addr_d = {base + 8'd2, base + 8'd1, base};
                    pix_d     = {I_OMCTL_PIX_R, I_OMCTL_PIX_G, I_OMCTL_PIX_B};
                    n_d       = n_q + 6'd1;
                    if (n_q == 6'(NPIX - 1)) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Last pixel commits this cycle; first read address goes out on the edge after.
                w_d = '0;
                for (int k = 0; k < 4; k++) out_addr_d[k] = word_byte_addr(6'd0, 2'(k));
                state_d = ST_WAIT_A;
            end
            ST_WAIT_A: state_d = ST_WAIT_B;
            ST_WAIT_B: state_d = ST_PRESENT;
            ST_PRESENT: begin
                if (I_OMCTL_WREADY) begin
                    if (w_q == 6'(NWORDS - 1)) begin
                        state_d = ST_FIN;
                    end else begin
                        w_d = w_q + 6'd1;
                        for (int k = 0; k < 4; k++) out_addr_d[k] = word_byte_addr(w_q + 6'd1, 2'(k));
                        state_d = ST_WAIT_A;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any tile in progress.
    always_ff @(posedge I_OMCTL_HCLK or negedge I_OMCTL_HRESET_N) begin
        if (!I_OMCTL_HRESET_N) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            w_q        <= '0;
            rot_q      <= '0;
            in_addr_q  <= {PARK_ADDR, PARK_ADDR, PARK_ADDR};
            pix_q      <= '0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            w_q        <= w_d;
            rot_q      <= rot_d;
            in_addr_q  <= in_addr_d;
            pix_q      <= pix_d;
            out_addr_q <= out_addr_d;
        end
    end

    assign O_OMCTL_PIX_READY = (state_q == ST_FILL);
    assign O_OMCTL_WVALID    = (state_q == ST_PRESENT);
    assign O_OMCTL_BUSY      = (state_q != ST_IDLE);
    assign O_OMCTL_DONE      = (state_q == ST_FIN);
    assign O_OMCTL_WORD_IDX  = w_q;

    assign O_OMCTL_IN_ADDRB  = in_addr_q[0];
    assign O_OMCTL_IN_ADDRG  = in_addr_q[1];
    assign O_OMCTL_IN_ADDRR  = in_addr_q[2];
    assign O_OMCTL_PIXEL_B   = pix_q[0];
    assign O_OMCTL_PIXEL_G   = pix_q[1];
    assign O_OMCTL_PIXEL_R   = pix_q[2];
    assign O_OMCTL_OUT_ADDR0 = out_addr_q[0];
    assign O_OMCTL_OUT_ADDR1 = out_addr_q[1];
    assign O_OMCTL_OUT_ADDR2 = out_addr_q[2];
    assign O_OMCTL_OUT_ADDR3 = out_addr_q[3];

endmodule

// File: tb/tb_output_mem_ctrl.sv
// Directed bench: behavioural 192-byte memory with 2-edge read latency plus word scoreboard.
module tb_output_mem_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] rot = 2'd0;
    logic       pvalid = 1'b0;
    logic       pready;
    logic [7:0] pb = 8'd0, pg = 8'd0, pr = 8'd0;
    logic [7:0] ob, og, orr, iab, iag, iar;
    logic [7:0] oa0, oa1, oa2, oa3;
    logic       wvalid;
    logic       wready = 1'b1;
    logic [5:0] widx;
    logic       busy, done;

    always #5 clk = ~clk;

    output_mem_ctrl dut (
        .I_OMCTL_HCLK(clk), .I_OMCTL_HRESET_N(rst_n), .I_OMCTL_START(start), .I_OMCTL_ROT(rot),
        .I_OMCTL_PIX_VALID(pvalid), .O_OMCTL_PIX_READY(pready),
        .I_OMCTL_PIX_B(pb), .I_OMCTL_PIX_G(pg), .I_OMCTL_PIX_R(pr),
        .O_OMCTL_PIXEL_B(ob), .O_OMCTL_PIXEL_G(og), .O_OMCTL_PIXEL_R(orr),
        .O_OMCTL_IN_ADDRB(iab), .O_OMCTL_IN_ADDRG(iag), .O_OMCTL_IN_ADDRR(iar),
        .O_OMCTL_OUT_ADDR0(oa0), .O_OMCTL_OUT_ADDR1(oa1), .O_OMCTL_OUT_ADDR2(oa2), .O_OMCTL_OUT_ADDR3(oa3),
        .O_OMCTL_WVALID(wvalid), .I_OMCTL_WREADY(wready), .O_OMCTL_WORD_IDX(widx),
        .O_OMCTL_BUSY(busy), .O_OMCTL_DONE(done)
    );

    int          n_cmp = 0, n_err = 0;
    int          done_cnt = 0, tile_pop = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_word[48];
    logic [31:0] gold0[48];
    int          dest_of[64];
    logic        clr_mem = 1'b0;

    // Behavioural memory, read pipeline and per-edge expectation capture.
    logic [7:0]  mem [192];
    logic [7:0]  rd1 [4];
    logic [7:0]  rd2 [4];
    logic        hs_prev = 1'b0;
    logic [7:0]  e_ib = 8'hFF, e_ig = 8'hFF, e_ir = 8'hFF;
    logic [23:0] e_px = 24'd0;
    logic [31:0] rword;

    assign rword = {rd2[3], rd2[2], rd2[1], rd2[0]};

    always @(posedge clk) begin
        hs_prev <= rst_n && pvalid && pready;
        if (rst_n && pvalid && pready) begin
            e_ib <= 8'(3 * dest_of[pb[5:0]]);
            e_ig <= 8'(3 * dest_of[pb[5:0]] + 1);
            e_ir <= 8'(3 * dest_of[pb[5:0]] + 2);
            e_px <= {pr, pg, pb};
        end else begin
            e_ib <= 8'hFF; e_ig <= 8'hFF; e_ir <= 8'hFF;
        end
        if (clr_mem) begin
            for (int i = 0; i < 192; i++) mem[i] <= 8'hEE;
        end else begin
            if (iab < 8'd192) mem[iab] <= ob;
            if (iag < 8'd192) mem[iag] <= og;
            if (iar < 8'd192) mem[iar] <= orr;
        end
        rd1[0] <= mem[oa0]; rd1[1] <= mem[oa1]; rd1[2] <= mem[oa2]; rd1[3] <= mem[oa3];
        rd2 <= rd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Per-negedge checks: write-address parking, write data, scoreboard pop.
    task automatic cyc_check();
        logic [31:0] e;
        if (!rst_n) return;
        chk("in_addr", 32'({iab, iag, iar}), 32'({e_ib, e_ig, e_ir}));
        if (hs_prev) chk("pixel_data", 32'({orr, og, ob}), 32'(e_px));
        if (done) done_cnt++;
        if (wvalid && wready) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_extra: observed word %08h expected none", rword);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("word_data", rword, e);
                chk("word_idx", 32'(widx), 32'(tile_pop));
                got_word[widx] = rword;
                tile_pop++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc_check();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_addr"}, 32'({iab, iag, iar}), 32'h00FF_FFFF);
        chk({tag, "_pixel"}, 32'({orr, og, ob}), 32'd0);
        chk({tag, "_out_addr"}, {oa3, oa2, oa1, oa0}, 32'd0);
        chk({tag, "_ctl"}, 32'({wvalid, pready, busy, done, widx}), 32'd0);
    endtask

    // Expected tile image built by walking destinations and finding each source pixel.
    task automatic build_tile(input int r);
        logic [7:0] em [192];
        int src, d;
        for (int rr = 0; rr < 8; rr++)
            for (int cc = 0; cc < 8; cc++) begin
                case (r)
                    1:       src = (7 - cc) * 8 + rr;
                    2:       src = (7 - rr) * 8 + (7 - cc);
                    3:       src = cc * 8 + (7 - rr);
                    default: src = rr * 8 + cc;
                endcase
                d = rr * 8 + cc;
                dest_of[src] = d;
                em[3*d]   = 8'(src);
                em[3*d+1] = 8'(8'h40 + src);
                em[3*d+2] = 8'(8'h80 + src);
            end
        exp_q.delete();
        for (int w = 0; w < 48; w++) exp_q.push_back({em[4*w+3], em[4*w+2], em[4*w+1], em[4*w]});
    endtask

    task automatic run_tile(input int r, input bit gaps, input int bp, input bit busy_start,
                            input int abort_at);
        int  t = 0, d0;
        bit  bp_done = 0, bs_done = 0;
        logic [31:0] hold;
        build_tile(r);
        tile_pop = 0;
        clr_mem = 1'b1;
        @(posedge clk); @(negedge clk);
        clr_mem = 1'b0;
        start = 1'b1; rot = 2'(r);
        tick();
        start = 1'b0;
        chk("fill_entry", 32'({busy, pready}), 32'h3);
        for (int n = 0; n < 64; n++) begin
            pvalid = 1'b1; pb = 8'(n); pg = 8'(8'h40 + n); pr = 8'(8'h80 + n);
            if (n == 0 || n == 63) chk("pix_ready", 32'(pready), 32'd1);
            tick();
            if (gaps) begin pvalid = 1'b0; tick(); end
        end
        pvalid = 1'b0;
        chk("fill_exit", 32'({busy, pready}), 32'h2);
        d0 = done_cnt;
        while (done_cnt == d0 && t < 2000) begin
            @(posedge clk); @(negedge clk); t++;
            if (abort_at >= 0 && wvalid && widx == 6'(abort_at)) return;
            if (bp >= 0 && !bp_done && wvalid && widx == 6'(bp)) begin
                hold = rword;
                wready = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    tick();
                    chk("bp_hold", 32'({wvalid, widx}), 32'h43);
                    chk("bp_addr", {oa3, oa2, oa1, oa0}, 32'h0F0E_0D0C);
                    chk("bp_data", rword, hold);
                end
                wready = 1'b1;
                bp_done = 1;
            end
            cyc_check();
            if (busy_start && !bs_done && tile_pop == 10) begin
                start = 1'b1; rot = 2'(r) ^ 2'd1;
                pvalid = 1'b1; pb = 8'hAA; pg = 8'hAA; pr = 8'hAA;
                tick();
                start = 1'b0; pvalid = 1'b0;
                bs_done = 1;
            end
        end
        chk("drain_timeout", 32'(t < 2000), 32'd1);
        chk("words_popped", 32'(tile_pop), 32'd48);
        chk("sb_left", 32'(exp_q.size()), 32'd0);
        tick(); tick();
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("idle_after", 32'({busy, wvalid}), 32'd0);
    endtask

    initial begin
        #12;
        chk_reset("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_tile(0, 0, -1, 0, -1);
        chk("rot0_word0", got_word[0], 32'h0180_4000);
        chk("rot0_word47", got_word[47], 32'hBF7F_3FBE);
        gold0 = got_word;

        run_tile(1, 0, -1, 0, -1);
        chk("rot90_word5", got_word[5], 32'h8040_0088);

        run_tile(0, 0, 3, 0, -1);
        chk("bp_word3", got_word[3], gold0[3]);

        run_tile(0, 1, -1, 0, -1);
        for (int w = 0; w < 48; w++) chk("gap_vs_gapfree", got_word[w], gold0[w]);

        run_tile(2, 0, -1, 1, -1);

        run_tile(3, 0, -1, 0, 20);
        chk("abort_point", 32'({wvalid, widx}), 32'h54);
        #1 rst_n = 1'b0;
        #1 chk_reset("rst_mid");
        exp_q.delete();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_reset("rst_rel");
        run_tile(3, 0, -1, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/output_mem_ctrl.md
Name: output_mem_ctrl

Overview:
- Sequencer for the 192-byte output pixel memory: one 8x8 RGB tile, 64 pixels x 3 bytes, byte address = 3*pixel + {0:B, 1:G, 2:R}.
- Fill phase: accepts a raster-order pixel stream and generates rotated write addresses (0/90/180/270 deg CW).
- Drain phase: generates the four byte-read addresses per 32-bit word and presents the 48 packed words to the AHB write master over a valid/ready handshake.
- The memory has no write enable, so the controller parks write addresses outside 0..191 whenever no pixel is being written.

Parameters:
- PARK_ADDR, 8'hFF, write address driven when idle; writes there are discarded.
- NPIX, 64, pixels per tile (8x8; not to be changed independently).
- NWORDS, 48, 32-bit words per tile (3*NPIX/4).

Ports:
- I_OMCTL_HCLK  in  1  clock.
- I_OMCTL_HRESET_N  in  1  asynchronous active-low reset.
- I_OMCTL_START  in  1  start-of-tile pulse; ignored unless IDLE.
- I_OMCTL_ROT  in  2  rotation 0/1/2/3 = 0/90/180/270 deg CW; latched on accepted START.
- I_OMCTL_PIX_VALID  in  1  input pixel valid.
- O_OMCTL_PIX_READY  out  1  pixel accepted when VALID&&READY.
- I_OMCTL_PIX_B, I_OMCTL_PIX_G, I_OMCTL_PIX_R  in  8 each  input pixel channels.
- O_OMCTL_PIXEL_B, O_OMCTL_PIXEL_G, O_OMCTL_PIXEL_R  out  8 each  registered write data to memory.
- O_OMCTL_IN_ADDRB, O_OMCTL_IN_ADDRG, O_OMCTL_IN_ADDRR  out  8 each  registered write addresses.
- O_OMCTL_OUT_ADDR0 .. O_OMCTL_OUT_ADDR3  out  8 each  read addresses; byte0 = least significant.
- O_OMCTL_WVALID  out  1  memory word output valid.
- I_OMCTL_WREADY  in  1  downstream accepts word.
- O_OMCTL_WORD_IDX  out  6  index (0..47) of the word presented.
- O_OMCTL_BUSY  out  1  high in every state except IDLE.
- O_OMCTL_DONE  out  1  one-cycle pulse when the tile is fully drained.

Behaviour:
- Reset (asynchronous, any state): state IDLE; IN_ADDR* = PARK_ADDR; PIXEL_* = 0; OUT_ADDR* = 0; WVALID, PIX_READY, BUSY, DONE = 0; counters and latched rotation = 0.
- FSM states: IDLE, FILL, FLUSH, WAIT_A, WAIT_B, PRESENT, FIN.
- IDLE -> FILL on START. Latch ROT; clear pixel counter n.
- FILL: PIX_READY = 1 (combinational from state).
  - On each handshake, register data and addresses: IN_ADDRB = 3*d, IN_ADDRG = 3*d+1, IN_ADDRR = 3*d+2.
  - With r = n[5:3] and c = n[2:0], d = 8*r'+c', where (r',c') is:
    - rot0: (r, c)
    - rot90: (c, 7-r)
    - rot180: (7-r, 7-c)
    - rot270: (7-c, r)
  - Cycle with no handshake: IN_ADDR* = PARK_ADDR; PIXEL_* hold.
  - Handshake at n = 63 -> FLUSH.
- FLUSH: one cycle with IN_ADDR* = PARK_ADDR, so the last write commits before any read. Then load OUT_ADDRk = 4*w+k with w = 0 -> WAIT_A.
- Read latency: the memory's word output is valid 2 edges after OUT_ADDR* changes. WAIT_A -> WAIT_B -> PRESENT unconditionally.
- PRESENT: WVALID = 1; OUT_ADDR* and WORD_IDX held stable.
  - Stall while WREADY = 0, indefinitely.
  - On WREADY with w < 47: w++, OUT_ADDR* update on the same edge -> WAIT_A. Peak rate is 1 word per 3 cycles.
  - On WREADY with w = 47 -> FIN.
- FIN: DONE = 1 for one cycle -> IDLE.
- In every state except FILL, IN_ADDR* = PARK_ADDR.
- START while BUSY is ignored; PIX_VALID outside FILL is ignored.
- Arithmetic: 3*d is at most 191 and fits in 8 bits; 4*w+3 is at most 191.
- Reset mid-fill or mid-drain aborts the tile; a partial tile is never resumed.

Decomposition:
- Shared package holds:
  - constants NPIX, NWORDS, PARK_ADDR, BYTES_PER_PIX = 3;
  - rotation encodings ROT_0, ROT_90, ROT_180, ROT_270;
  - state encoding localparams.
- Sub-module omctl_rot_addr (combinational): inputs n[5:0] and rot[1:0]; output base byte address 3*d. It is separately unit-testable against all 256 input combinations.

Test Plan:
- rot0, pixel n with B=n, G=0x40+n, R=0x80+n, PIX_VALID constant, WREADY tied high -> 48 words; word0 = 0x01804000, word47 = 0xBF7F3FBE (bytes 188..191); DONE pulses once.
- rot90, same stimulus -> word5 (bytes 20..23) = 0x80400088, i.e. byte20 = R of source n=8 and bytes 21..23 = B,G,R of source n=0.
- Backpressure: WREADY low for 10 cycles while word3 is presented -> WVALID stays high; OUT_ADDR* = 12..15, WORD_IDX = 3 and word data unchanged throughout; resumes correctly afterwards.
- Gaps in PIX_VALID (every other cycle) -> IN_ADDR* = 0xFF in gap cycles; final contents identical to gap-free run; FLUSH occurs exactly once after n = 63.
- Park check: during FLUSH through FIN, all IN_ADDR* = 0xFF every cycle. START pulsed while BUSY has no effect (ROT change not latched).
- Async reset asserted mid-drain (word 20) -> outputs at reset values immediately, no clock edge needed; a new START then yields a full correct 48-word tile.
